// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM states and opcode-class helpers for the
// sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_MUL   = 4'd7,
    OP_SRA   = 4'd8,
    OP_SLT   = 4'd9,
    OP_SLTU  = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13
  } alu_op_e;

  // Every code from here up to 4'd15 is undefined.
  localparam logic [3:0] OP_ILLEGAL_LO = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    case (op)
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= OP_ILLEGAL_LO;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative unit: shift-add multiplier and restoring divider sharing
// one accumulator pair and one XLEN-step counter.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;
  logic [XLEN-1:0] opnd_r;
  logic            div_r;

  logic [XLEN:0]   mul_sum_s;
  logic [XLEN:0]   div_shift_s;
  logic [XLEN:0]   div_diff_s;
  logic [XLEN-1:0] hi_nx_s;
  logic [XLEN-1:0] lo_nx_s;

  // One iteration step; outputs expose the post-step value so the final
  // step's result can be captured on the same edge that ends the operation.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    div_shift_s = {hi_r, lo_r[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (div_r) begin
      if (!div_diff_s[XLEN]) begin
        hi_nx_s = div_diff_s[XLEN-1:0];
        lo_nx_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        hi_nx_s = div_shift_s[XLEN-1:0];
        lo_nx_s = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx_s = mul_sum_s[XLEN:1];
      lo_nx_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  assign done      = (cnt_r == CW'(1));
  assign lo        = lo_nx_s;
  assign hi        = hi_nx_s;
  assign quotient  = lo_nx_s;
  assign remainder = hi_nx_s;

  // Operand load on start, then one step per cycle while the counter runs.
  // A zero divisor needs no special case: every trial subtract succeeds, so
  // the quotient fills with ones and the dividend shifts into the remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CW{1'b0}};
      hi_r   <= {XLEN{1'b0}};
      lo_r   <= {XLEN{1'b0}};
      opnd_r <= {XLEN{1'b0}};
      div_r  <= 1'b0;
    end else if (start) begin
      cnt_r  <= CW'(XLEN);
      hi_r   <= {XLEN{1'b0}};
      lo_r   <= is_div(op) ? a : b;
      opnd_r <= is_div(op) ? b : a;
      div_r  <= is_div(op);
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - CW'(1);
      hi_r  <= hi_nx_s;
      lo_r  <= lo_nx_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle datapath plus an iterative mul/div unit,
// with a registered result held until the consumer takes it.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [3:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_dbz,
  output logic            out_illegal
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_r, state_nx_s;
  logic            accept_s;
  logic            in_ready_s;
  logic [3:0]      op_r;
  logic [XLEN-1:0] result_r;
  logic            valid_r, zero_r, dbz_r, illegal_r;
  logic [XLEN-1:0] alu_res_s;
  logic [XLEN-1:0] md_res_s;
  logic [SHW-1:0]  shamt_s;
  logic            md_done_s;
  logic [XLEN-1:0] md_lo_s, md_hi_s, md_quo_s, md_rem_s;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_s && is_multicycle(in_op)),
    .op        (in_op),
    .a         (in_a),
    .b         (in_b),
    .done      (md_done_s),
    .lo        (md_lo_s),
    .hi        (md_hi_s),
    .quotient  (md_quo_s),
    .remainder (md_rem_s)
  );

  // Single-cycle datapath; multicycle and illegal codes fall to zero.
  always_comb begin
    shamt_s = in_b[SHW-1:0];
    case (in_op)
      OP_ADD:  alu_res_s = in_a + in_b;
      OP_SUB:  alu_res_s = in_a - in_b;
      OP_AND:  alu_res_s = in_a & in_b;
      OP_OR:   alu_res_s = in_a | in_b;
      OP_XOR:  alu_res_s = in_a ^ in_b;
      OP_SLL:  alu_res_s = in_a << shamt_s;
      OP_SRL:  alu_res_s = in_a >> shamt_s;
      OP_SRA:  alu_res_s = $signed(in_a) >>> shamt_s;
      OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default: alu_res_s = {XLEN{1'b0}};
    endcase
  end

  // Select which iterative output the latched op wants.
  always_comb begin
    case (op_r)
      OP_MUL:   md_res_s = md_lo_s;
      OP_MULHU: md_res_s = md_hi_s;
      OP_DIVU:  md_res_s = md_quo_s;
      OP_REMU:  md_res_s = md_rem_s;
      default:  md_res_s = {XLEN{1'b0}};
    endcase
  end

  // Handshake and next-state logic; DONE accepts a new op in the same cycle
  // its result is consumed.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_DONE: in_ready_s = out_ready;
      default: in_ready_s = 1'b0;
    endcase
    accept_s = in_valid && in_ready_s;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = is_multicycle(in_op) ? ST_BUSY : ST_DONE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (md_done_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (accept_s) begin
          state_nx_s = is_multicycle(in_op) ? ST_BUSY : ST_DONE;
        end else if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      valid_r   <= 1'b0;
      op_r      <= 4'd0;
      result_r  <= {XLEN{1'b0}};
      zero_r    <= 1'b1;
      dbz_r     <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      valid_r <= (state_nx_s == ST_DONE);
      if (accept_s) begin
        op_r      <= in_op;
        dbz_r     <= is_div(in_op) && (in_b == {XLEN{1'b0}});
        illegal_r <= is_illegal(in_op);
        if (!is_multicycle(in_op)) begin
          result_r <= alu_res_s;
          zero_r   <= (alu_res_s == {XLEN{1'b0}});
        end else begin
          result_r <= result_r;
        end
      end else if ((state_r == ST_BUSY) && md_done_s) begin
        result_r <= md_res_s;
        zero_r   <= (md_res_s == {XLEN{1'b0}});
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = valid_r;
  assign out_result  = result_r;
  assign out_zero    = zero_r;
  assign out_dbz     = dbz_r;
  assign out_illegal = illegal_r;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the core 64-bit ALU.
- Adds signed shifts and compares, a high-half multiply, and unsigned divide/remainder, with a registered result and valid/ready flow control on both sides.
- Single-cycle ops complete in 1 cycle. MUL/MULHU/DIVU/REMU run on an iterative radix-2 unit taking XLEN cycles.
- Sits between the decode/issue stage and writeback; the issue stage stalls on in_ready.

Parameters:
- XLEN, 64: operand/result width; power of 2, >= 8.
- SHW, $clog2(XLEN): shift-amount width (derived; not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept this cycle.
- in_a  input  XLEN  operand A.
- in_b  input  XLEN  operand B.
- in_op  input  4  operation select (alu_pkg opcodes).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_result  output  XLEN  result.
- out_zero  output  1  out_result == 0.
- out_dbz  output  1  DIVU/REMU with in_b == 0.
- out_illegal  output  1  undefined opcode.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL (low XLEN), 8 SRA, 9 SLT (signed, result 0/1), 10 SLTU, 11 MULHU (high XLEN of unsigned product), 12 DIVU, 13 REMU. Codes 14 and 15 are illegal.
- Shifts use in_b[SHW-1:0] only. Add, sub and low multiply wrap modulo 2^XLEN.
- Transfer: an input is accepted when in_valid && in_ready. An output is consumed when out_valid && out_ready.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - Accept of a single-cycle or illegal op: compute, register the result, go to DONE. out_valid is high in the cycle after accept (latency 1).
  - Accept of MUL/MULHU/DIVU/REMU: latch operands, load counter = XLEN, go to BUSY.
- BUSY: one iteration per cycle, counter decrements. After counter reaches 0, go to DONE. out_valid rises XLEN+1 cycles after accept.
- DONE:
  - out_valid = 1. out_result and all flags are held stable while out_ready = 0.
  - out_ready = 1 with no new accept: go to IDLE.
- in_ready = 1 in IDLE, and in DONE when out_ready = 1 (allows back-to-back issue). In that case the new op is accepted in the same cycle the old result is consumed, and the FSM goes directly to DONE or BUSY. in_ready = 0 in BUSY.
- Divide by zero: DIVU result = all-ones, REMU result = in_a, out_dbz = 1. Takes the normal XLEN-cycle latency; no early exit.
- Illegal op: out_result = 0, out_zero = 1, out_illegal = 1, latency 1.
- Flag scope: out_dbz and out_illegal are valid only with out_valid. They clear on the next accepted op.
- Reset (sync, rst = 1 at a clock edge):
  - state = IDLE; out_valid = 0; out_result = 0; out_dbz = 0; out_illegal = 0; counter = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - A reset mid-BUSY abandons the operation. No result is produced.
- in_valid is ignored while in_ready = 0. Operands need not be held after accept.

Decomposition:
- alu_pkg holds:
  - the 4-bit op enum and its values;
  - an is_multicycle(op) function;
  - the illegal-op range.
- Sub-module alu_muldiv_iter: shift-add multiplier (2·XLEN product register) and restoring divider sharing one XLEN-step counter.
  - Interface: start, op, a, b → done pulse, lo, hi, quotient, remainder.
  - alu_seq owns the FSM, the handshake and the single-cycle datapath.

Test Plan (XLEN = 64):
- ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1, out_ready=1 → out_valid next cycle, result 0, out_zero=1.
- SRA a=0x8000_0000_0000_0000, b=0x43 (shamt 3) → 0xF000_0000_0000_0000. SLT a=-1, b=1 → 1; SLTU with same operands → 0.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → in_ready low for 64 cycles, out_valid at cycle 65, result 0xFFFF_FFFF_FFFF_FFFE.
- DIVU a=100, b=7 → 14; REMU → 2. DIVU a=5, b=0 → 0xFFFF_FFFF_FFFF_FFFF with out_dbz=1; REMU a=5, b=0 → 5 with out_dbz=1.
- Backpressure: ADD result held with out_ready=0 for 5 cycles → result stable, in_ready=0. Then out_ready=1 with next op valid → both transfers occur in the same cycle.
- Reset asserted at BUSY cycle 20 of a DIVU → next cycle out_valid=0, in_ready=1, out_result=0; no stale result appears. Op 15 → out_illegal=1, result 0.
